// File: rtl/instr_fetch_queue_if.sv
// Fetch-queue bus: decoder handshake plus instruction memory port.
// master = fetch unit, slave = decoder/memory side.
interface instr_fetch_queue_if;
  logic        to_dec;
  logic [31:0] to_dec_pc;
  logic [31:0] to_dec_inst;
  logic        dec_ready;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_valid;
  logic [31:0] mem_data;

  modport master (
    output to_dec, to_dec_pc, to_dec_inst,
    output mem_req, mem_addr,
    input  dec_ready, mem_valid, mem_data
  );

  modport slave (
    input  to_dec, to_dec_pc, to_dec_inst,
    input  mem_req, mem_addr,
    output dec_ready, mem_valid, mem_data
  );
endinterface

// File: rtl/instr_fetch_queue.sv
// Instruction fetch front end: one outstanding word fetch,
// small PC/instruction queue toward the decoder, clear redirect.
module instr_fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IQ_WIDTH = 2,
  parameter int          IQ_SIZE  = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        clear,
  input  logic [31:0] clear_pc,
  instr_fetch_queue_if.master bus
);

  localparam int CW = IQ_WIDTH + 1;
  localparam logic [CW-1:0] FULL = CW'(IQ_SIZE);
  localparam logic [IQ_WIDTH-1:0] PTR_ONE = IQ_WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DROP
  } state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  state_t              state_q, state_d;
  logic [31:0]         pc_q, pc_d;
  logic [IQ_WIDTH-1:0] head_q, head_d;
  logic [IQ_WIDTH-1:0] tail_q, tail_d;
  logic [CW-1:0]       count_q, count_d;
  logic                mem_req_q, mem_req_d;
  logic [31:0]         mem_addr_q, mem_addr_d;
  entry_t              iq_q [IQ_SIZE];
  logic                push;
  logic                pop;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    push       = 1'b0;
    pop        = 1'b0;
    if (rdy_in) begin
      mem_req_d = 1'b0;
      if (clear) begin
        head_d  = '0;
        tail_d  = '0;
        count_d = '0;
        pc_d    = clear_pc;
        // an outstanding response must be swallowed before refetching
        unique case (state_q)
          IDLE:       state_d = IDLE;
          WAIT, DROP: state_d = bus.mem_valid ? IDLE : DROP;
          default:    state_d = IDLE;
        endcase
      end else begin
        pop  = (count_q != '0) && bus.dec_ready;
        push = (state_q == WAIT) && bus.mem_valid;
        if (pop) head_d = head_q + PTR_ONE;
        if (push) begin
          tail_d = tail_q + PTR_ONE;
          pc_d   = pc_q + 32'd4;
        end
        count_d = count_q + CW'(push) - CW'(pop);
        // slot is reserved here, so the later push cannot overflow
        unique case (state_q)
          IDLE: begin
            if (count_d < FULL) begin
              mem_req_d  = 1'b1;
              mem_addr_d = pc_q;
              state_d    = WAIT;
            end
          end
          WAIT:    if (bus.mem_valid) state_d = IDLE;
          DROP:    if (bus.mem_valid) state_d = IDLE;
          default: state_d = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      for (int i = 0; i < IQ_SIZE; i++) begin
        iq_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      if (push) begin
        iq_q[tail_q] <= {pc_q, bus.mem_data};
      end
    end
  end

  assign bus.to_dec      = (count_q != '0);
  assign bus.to_dec_pc   = iq_q[head_q].pc;
  assign bus.to_dec_inst = iq_q[head_q].inst;
  assign bus.mem_req     = mem_req_q;
  assign bus.mem_addr    = mem_addr_q;

endmodule
